error_logger: RTL and testbench
===============================

Name: error_logger

Overview:
- Sits directly downstream of the parity error-detection stage.
- Consumes its per-cycle data_error / instruction_error pulses, together with the address/PC associated with the checked word.
- Records each error event in a small first-word-fall-through FIFO for software readout and raises an interrupt while records are pending.
- Runs a NORMAL/ALERT/HALT fault state machine that requests a CPU halt after a burst of consecutive error cycles.

Parameters:
- DEPTH, 4, number of FIFO records (power of two, 2..16).
- ADDR_W, 8, width of the logged address.
- HALT_THRESH, 3, consecutive error cycles that force HALT (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- data_error  in  1  data parity error pulse from the detection stage.
- instruction_error  in  1  instruction parity error pulse from the detection stage.
- err_addr  in  ADDR_W  address/PC associated with the checked word in the same cycle.
- pop  in  1  consumer acknowledges and removes the head record.
- clear_halt  in  1  software release of HALT; also clears overflow and the consecutive counter.
- log_valid  out  1  FIFO non-empty (head record valid).
- log_type  out  2  head record type {instruction_error, data_error}.
- log_addr  out  ADDR_W  head record address.
- log_count  out  clog2(DEPTH+1)  records held (0..DEPTH).
- overflow  out  1  sticky: at least one event was dropped because the FIFO was full.
- irq  out  1  interrupt: log_valid | halt_req.
- halt_req  out  1  high in HALT state.
- state  out  2  0 = NORMAL, 1 = ALERT, 2 = HALT.

Behaviour:
- Reset (async, immediate): FIFO empty, log_count = 0, log_valid = 0, log_type = 0, log_addr = 0, overflow = 0, halt_req = 0, irq = 0, state = NORMAL, consecutive counter = 0. Reset mid-operation discards all records.
- Event: ev = data_error | instruction_error, sampled at the rising edge. Record = {instruction_error, data_error, err_addr}. A single record is written when both error bits are set (type 2'b11).
- Push:
  - On an ev edge with the FIFO not full, the record is written at the tail.
  - The record is visible on log_* after that edge (1-cycle latency) if the FIFO was empty.
- Pop:
  - pop with log_valid=1 advances the head on the edge.
  - pop with the FIFO empty is ignored; no underflow and no state change.
- Simultaneous push and pop:
  - FIFO not empty: both occur and log_count is unchanged.
  - FIFO full: the slot freed by the pop accepts the push, with no drop and no overflow.
  - FIFO empty: the pop is ignored and the push is accepted.
- Full: ev without a same-cycle pop drops the record and sets overflow = 1. overflow stays set until clear_halt or rst.
- Pointers wrap modulo DEPTH. log_count is maintained explicitly, with no full/empty ambiguity.
- log_valid = (log_count != 0). log_type and log_addr come from the head register/array, and are don't-care when log_valid=0 (the bench checks only when valid).
- Consecutive counter:
  - +1 on each ev edge, saturating at HALT_THRESH.
  - Cleared on any edge with ev=0.
  - Cleared by clear_halt, which takes priority over an increment.
- FSM, evaluated each edge using the next value of the consecutive counter (cnext):
  - NORMAL: on ev, go to HALT if cnext >= HALT_THRESH, else go to ALERT.
  - ALERT: go to HALT if cnext >= HALT_THRESH. Otherwise return to NORMAL when ev=0 and log_count (after this edge's pop) = 0. Otherwise stay in ALERT.
  - HALT: stay until clear_halt=1, then go to NORMAL even if ev=1 in the same cycle. In that case the event is still logged, and FSM evaluation resumes on the next edge.
  - clear_halt outside HALT: clears only overflow and the counter; no state change.
- Events arriving in HALT are still logged, drop rules apply, and FIFO contents survive clear_halt.
- halt_req = (state == HALT). irq = log_valid | halt_req (combinational from registers).

Test Plan:
- Reset, then ev for one cycle with data_error=1 and err_addr=0x3C -> next cycle log_valid=1, log_type=01, log_addr=0x3C, log_count=1, state=ALERT, irq=1. Then pop -> log_count=0, and state returns to NORMAL after the next ev-free edge.
- 5 non-consecutive events (ev=1 and 0 alternating) with addrs 0x10..0x14, no pop -> log_count=4, overflow=1, and popping yields 0x10, 0x11, 0x12, 0x13 in order with no HALT.
- FIFO full (4 records), then ev (addr 0x55) and pop in the same cycle -> log_count stays 4, overflow stays 0, and the last record read is 0x55.
- 3 consecutive ev cycles (HALT_THRESH=3), both error bits on the 2nd -> state NORMAL, ALERT, ALERT, HALT; halt_req=1 after the 3rd edge; middle record type=11.
- In HALT: pulse clear_halt with ev=1 (addr 0x7E) -> state=NORMAL, overflow=0, 0x7E logged, and earlier records intact.
- Assert rst asynchronously mid-cycle while the FIFO holds 3 records and state=HALT -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/error_logger.sv
// error_logger
//   Sits behind the parity error-detection stage. Every cycle with a data or
//   instruction parity error is logged as one record {instruction_error,
//   data_error, err_addr} in a small first-word-fall-through FIFO. An
//   interrupt is raised while records are pending or a halt is requested.
//   A NORMAL/ALERT/HALT state machine requests a CPU halt after a burst of
//   HALT_THRESH consecutive error cycles.
//
// Ports
//   clk                rising-edge clock
//   rst                asynchronous, active-high reset
//   data_error         data parity error pulse
//   instruction_error  instruction parity error pulse
//   err_addr           address/PC of the checked word in the same cycle
//   pop                remove the head record (ignored when empty)
//   clear_halt         release HALT; also clears overflow and the burst counter
//   log_valid          head record valid (FIFO non-empty)
//   log_type           head record type {instruction_error, data_error}
//   log_addr           head record address
//   log_count          number of records held (0..DEPTH)
//   overflow           sticky: an event was dropped because the FIFO was full
//   irq                log_valid | halt_req
//   halt_req           high in HALT
//   state              0 = NORMAL, 1 = ALERT, 2 = HALT
module error_logger #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 8,
  parameter int HALT_THRESH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_error,
  input  logic                       instruction_error,
  input  logic [ADDR_W-1:0]          err_addr,
  input  logic                       pop,
  input  logic                       clear_halt,
  output logic                       log_valid,
  output logic [1:0]                 log_type,
  output logic [ADDR_W-1:0]          log_addr,
  output logic [$clog2(DEPTH+1)-1:0] log_count,
  output logic                       overflow,
  output logic                       irq,
  output logic                       halt_req,
  output logic [1:0]                 state
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CON_W = 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ALERT  = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // Burst counter saturates at the threshold so it never wraps during a
  // long error storm.
  function automatic logic [CON_W-1:0] sat_inc(input logic [CON_W-1:0] v);
    if (v >= CON_W'(HALT_THRESH)) return CON_W'(HALT_THRESH);
    else                          return v + CON_W'(1);
  endfunction

  // Record storage holds data only; validity is tracked by count, so it
  // carries no reset.
  logic [1:0]        type_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             ov;
  logic [CON_W-1:0] consec;
  state_t           st;

  logic             ev;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  logic [CNT_W-1:0] count_nxt;
  logic [CON_W-1:0] consec_nxt;
  logic             thresh_hit;

  always_comb begin
    ev      = data_error | instruction_error;
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop && (count != '0);
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    do_push = ev && (!full || do_pop);
    drop    = ev && full && !do_pop;
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clear_halt)  consec_nxt = '0;
    else if (ev)     consec_nxt = sat_inc(consec);
    else             consec_nxt = '0;
    thresh_hit = (consec_nxt >= CON_W'(HALT_THRESH));
  end

  // Record write port
  always_ff @(posedge clk) begin
    if (do_push) begin
      type_mem[tail] <= {instruction_error, data_error};
      addr_mem[tail] <= err_addr;
    end
  end

  // Control: pointers, occupancy, overflow, burst counter and fault FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ov     <= 1'b0;
      consec <= '0;
      st     <= ST_NORMAL;
    end else begin
      if (do_pop)  head <= head + PTR_W'(1);
      if (do_push) tail <= tail + PTR_W'(1);
      count  <= count_nxt;
      consec <= consec_nxt;
      if (clear_halt) ov <= 1'b0;
      else if (drop)  ov <= 1'b1;
      case (st)
        ST_NORMAL: begin
          if (ev) st <= thresh_hit ? ST_HALT : ST_ALERT;
        end
        ST_ALERT: begin
          if (thresh_hit)                    st <= ST_HALT;
          else if (!ev && count_nxt == '0)   st <= ST_NORMAL;
        end
        ST_HALT: begin
          // Release wins over any same-cycle event; evaluation resumes next edge.
          if (clear_halt) st <= ST_NORMAL;
        end
        default: st <= ST_NORMAL;
      endcase
    end
  end

  // Head fields are masked when empty so reset presents all-zero outputs.
  always_comb begin
    log_valid = (count != '0);
    log_type  = log_valid ? type_mem[head] : 2'b00;
    log_addr  = log_valid ? addr_mem[head] : '0;
    log_count = count;
    overflow  = ov;
    halt_req  = (st == ST_HALT);
    irq       = log_valid | halt_req;
    state     = st;
  end

endmodule

// File: tb/tb_error_logger.sv
module tb_error_logger;

  localparam int DEPTH = 4;
  localparam int ADDR_W = 8;
  localparam int TH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_error, instruction_error, pop, clear_halt;
  logic [ADDR_W-1:0] err_addr;
  logic              log_valid, overflow, irq, halt_req;
  logic [1:0]        log_type, state;
  logic [ADDR_W-1:0] log_addr;
  logic [2:0]        log_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queue of records plus scalar status.
  logic [ADDR_W+1:0] mq[$];
  int                m_cnt;
  int                m_st;
  bit                m_ov;

  error_logger #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_THRESH(TH)) dut (
    .clk(clk), .rst(rst),
    .data_error(data_error), .instruction_error(instruction_error),
    .err_addr(err_addr), .pop(pop), .clear_halt(clear_halt),
    .log_valid(log_valid), .log_type(log_type), .log_addr(log_addr),
    .log_count(log_count), .overflow(overflow), .irq(irq),
    .halt_req(halt_req), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mq.delete();
    m_cnt = 0;
    m_st  = 0;
    m_ov  = 1'b0;
  endtask

  task automatic mdl_step(input bit de, input bit ie, input logic [ADDR_W-1:0] a,
                          input bit p, input bit c);
    bit ev, drop;
    int cn;
    ev = de | ie;
    drop = 1'b0;
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (ev) begin
      if (mq.size() < DEPTH) mq.push_back({ie, de, a});
      else drop = 1'b1;
    end
    if (c) m_ov = 1'b0;
    else if (drop) m_ov = 1'b1;
    if (c) cn = 0;
    else if (ev) cn = (m_cnt + 1 > TH) ? TH : m_cnt + 1;
    else cn = 0;
    case (m_st)
      0: if (ev) m_st = (cn >= TH) ? 2 : 1;
      1: if (cn >= TH) m_st = 2;
         else if (!ev && mq.size() == 0) m_st = 0;
      default: if (c) m_st = 0;
    endcase
    m_cnt = cn;
  endtask

  task automatic check_all(input string tag);
    logic [ADDR_W+1:0] h;
    chk({tag, "_valid"}, 32'(log_valid), 32'(mq.size() != 0));
    chk({tag, "_count"}, 32'(log_count), 32'(mq.size()));
    chk({tag, "_ovf"},   32'(overflow),  32'(m_ov));
    chk({tag, "_state"}, 32'(state),     32'(m_st));
    chk({tag, "_halt"},  32'(halt_req),  32'(m_st == 2));
    chk({tag, "_irq"},   32'(irq),       32'((mq.size() != 0) || (m_st == 2)));
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, "_type"}, 32'(log_type), 32'(h[ADDR_W+1:ADDR_W]));
      chk({tag, "_addr"}, 32'(log_addr), 32'(h[ADDR_W-1:0]));
    end
  endtask

  task automatic cyc(input string tag, input bit de, input bit ie,
                     input logic [ADDR_W-1:0] a, input bit p, input bit c);
    data_error = de; instruction_error = ie; err_addr = a; pop = p; clear_halt = c;
    @(posedge clk);
    mdl_step(de, ie, a, p, c);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(log_valid), 32'd0);
    chk({tag, "_count"}, 32'(log_count), 32'd0);
    chk({tag, "_type"},  32'(log_type),  32'd0);
    chk({tag, "_addr"},  32'(log_addr),  32'd0);
    chk({tag, "_ovf"},   32'(overflow),  32'd0);
    chk({tag, "_irq"},   32'(irq),       32'd0);
    chk({tag, "_halt"},  32'(halt_req),  32'd0);
    chk({tag, "_state"}, 32'(state),     32'd0);
  endtask

  initial begin
    int dens;
    rst = 1'b1;
    data_error = 1'b0; instruction_error = 1'b0; err_addr = '0;
    pop = 1'b0; clear_halt = 1'b0;
    mdl_reset();
    #12;
    check_zero("reset");
    rst = 1'b0;

    // Single data error, then pop
    cyc("t1_ev", 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    chk("t1_addr", 32'(log_addr), 32'h3C);
    chk("t1_type", 32'(log_type), 32'h1);
    chk("t1_st",   32'(state),    32'd1);
    cyc("t1_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_cnt0", 32'(log_count), 32'd0);
    chk("t1_norm", 32'(state), 32'd0);

    // Five spaced events overflow a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      cyc("t2_ev", 1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
      idle("t2_gap");
    end
    chk("t2_cnt", 32'(log_count), 32'd4);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_head", 32'(log_addr), 32'(8'h10 + i));
      chk("t2_nohalt", 32'(halt_req), 32'd0);
      cyc("t2_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    cyc("t2_clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf0", 32'(overflow), 32'd0);

    // Full FIFO: simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      cyc("t3_fill", 1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
      idle("t3_gap");
    end
    cyc("t3_pp", 1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("t3_cnt", 32'(log_count), 32'd4);
    chk("t3_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) cyc("t3_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_last", 32'(log_addr), 32'h55);
    cyc("t3_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Burst of three consecutive error cycles
    chk("t4_s0", 32'(state), 32'd0);
    cyc("t4_e1", 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
    chk("t4_s1", 32'(state), 32'd1);
    cyc("t4_e2", 1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
    chk("t4_s2", 32'(state), 32'd1);
    cyc("t4_e3", 1'b1, 1'b0, 8'h32, 1'b0, 1'b0);
    chk("t4_s3", 32'(state), 32'd2);
    chk("t4_halt", 32'(halt_req), 32'd1);
    idle("t4_hold");

    // Release HALT with a same-cycle event
    cyc("t5_clr", 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1);
    chk("t5_st", 32'(state), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_cnt", 32'(log_count), 32'd4);
    chk("t5_h0", 32'(log_addr), 32'h30);
    cyc("t5_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_mid", 32'(log_type), 32'h3);
    chk("t5_h1", 32'(log_addr), 32'h31);
    cyc("t5_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("t5_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_h3", 32'(log_addr), 32'h7E);
    chk("t5_t3", 32'(log_type), 32'h2);
    cyc("t5_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with 3 records in HALT
    cyc("t6_e1", 1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
    cyc("t6_e2", 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    cyc("t6_e3", 1'b1, 1'b0, 8'h43, 1'b0, 1'b0);
    chk("t6_pre_st", 32'(state), 32'd2);
    chk("t6_pre_cnt", 32'(log_count), 32'd3);
    data_error = 1'b0; err_addr = '0;
    #2;
    rst = 1'b1;
    mdl_reset();
    #1;
    check_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      dens = ((i / 100) % 2 == 1) ? 80 : 25;
      cyc("rnd",
          ($urandom_range(0, 99) < dens),
          ($urandom_range(0, 99) < dens / 3),
          8'($urandom),
          ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
